// File: rtl/note_pkg.sv
// ---------------------------------------------------------------------------
// note_pkg
// Shared definitions for the monophonic note-priority allocator.
//   NOTE_W_DEFAULT : default note-number width (MIDI range, 128 keys)
//   mode_e         : run-time priority selection
//   state_e        : allocator FSM states
//   scan_dir_up    : which scan direction a given mode uses
// ---------------------------------------------------------------------------
package note_pkg;

  localparam int NOTE_W_DEFAULT = 7;

  // Priority modes. The reserved encoding behaves like MODE_HIGH.
  typedef enum logic [1:0] {
    MODE_HIGH = 2'd0,
    MODE_LOW  = 2'd1,
    MODE_LAST = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Only lowest-note priority walks the bitmap upward; highest, reserved
  // and the last-note fallback all look for the highest held key.
  function automatic logic scan_dir_up(input logic [1:0] m);
    return (m == MODE_LOW);
  endfunction

endpackage

// File: rtl/note_scan_ptr.sv
// ---------------------------------------------------------------------------
// note_scan_ptr
// Up/down pointer that walks the key bitmap one bit per cycle.
// Ports:
//   clk         : system clock, rising edge
//   rst         : asynchronous reset, active-low
//   load        : move to the start position for direction up_start
//   up_start    : direction to latch on load (1 = from 0 upward)
//   step        : advance one position in the latched direction
//   ptr         : current bitmap index under test
//   at_terminal : ptr is the last position for the latched direction
// ---------------------------------------------------------------------------
module note_scan_ptr
  import note_pkg::*;
#(
  parameter int NOTE_W = NOTE_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              up_start,
  input  logic              step,
  output logic [NOTE_W-1:0] ptr,
  output logic              at_terminal
);

  logic up;

  // Direction is captured at load so a mode change during a scan cannot
  // flip the walk halfway; a restart reloads both position and direction.
  // Load wins over step so a restart always begins at the start position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      up  <= 1'b0;
    end else if (load) begin
      up  <= up_start;
      ptr <= up_start ? '0 : '1;
    end else if (step) begin
      ptr <= up ? (ptr + NOTE_W'(1)) : (ptr - NOTE_W'(1));
    end
  end

  // The owner tests the terminal bit before stepping, so the pointer never
  // needs to wrap.
  assign at_terminal = up ? (ptr == '1) : (ptr == '0);

endmodule

// File: rtl/note_mono_prio.sv
// ---------------------------------------------------------------------------
// note_mono_prio
// Monophonic note-priority allocator. Tracks held keys from note_on/note_off
// events and selects one note plus a gate for the voice, with highest,
// lowest or last-pressed priority chosen at run time.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active-low
//   note_on    : 1-cycle strobe, key `note` pressed
//   note_off   : 1-cycle strobe, key `note` released
//   note       : key number qualifying note_on/note_off
//   all_off    : 1-cycle strobe, release every key
//   mode       : 0 highest, 1 lowest, 2 last, 3 treated as highest
//   out_note   : selected note, held after the gate falls
//   out_gate   : 1 while a held key is selected
//   out_retrig : 1-cycle envelope retrigger, coincident with output update
//   busy       : 1 while the bitmap is being scanned
// ---------------------------------------------------------------------------
module note_mono_prio
  import note_pkg::*;
#(
  parameter int NOTE_W        = NOTE_W_DEFAULT,
  parameter bit RETRIG_LEGATO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              note_on,
  input  logic              note_off,
  input  logic [NOTE_W-1:0] note,
  input  logic              all_off,
  input  logic [1:0]        mode,
  output logic [NOTE_W-1:0] out_note,
  output logic              out_gate,
  output logic              out_retrig,
  output logic              busy
);

  localparam int KEYS = 2 ** NOTE_W;

  logic [KEYS-1:0]   keys;
  logic [KEYS-1:0]   keys_next;
  state_e            state;
  state_e            state_next;
  logic [1:0]        mode_q;
  logic [NOTE_W-1:0] note_next;
  logic              gate_next;

  logic [NOTE_W-1:0] ptr;
  logic              at_terminal;
  logic              ptr_load;
  logic              ptr_step;

  logic              mode_change;
  logic              is_last;
  logic              off_hits_out;
  logic              direct_sel;
  logic              scan_req;

  note_scan_ptr #(
    .NOTE_W (NOTE_W)
  ) u_scan_ptr (
    .clk         (clk),
    .rst         (rst),
    .load        (ptr_load),
    .up_start    (scan_dir_up(mode)),
    .step        (ptr_step),
    .ptr         (ptr),
    .at_terminal (at_terminal)
  );

  // Bitmap update. Only one event takes effect per cycle, so a note_on and
  // note_off for the same key in one cycle leaves the key held.
  always_comb begin
    keys_next = keys;
    if (all_off) begin
      keys_next = '0;
    end else if (note_on) begin
      keys_next[note] = 1'b1;
    end else if (note_off) begin
      keys_next[note] = 1'b0;
    end
  end

  // Event classification. In last-note mode a release only matters when it
  // removes the note currently sounding; the fallback scan then looks for
  // the highest remaining key.
  assign mode_change  = (mode != mode_q);
  assign is_last      = (mode == MODE_LAST);
  assign off_hits_out = (note == out_note) && out_gate;
  assign direct_sel   = note_on && is_last;
  assign scan_req     = mode_change
                      || (note_on && !is_last)
                      || (note_off && !note_on && (!is_last || off_hits_out));

  // Next-state and next-output selection. A scan always starts one cycle
  // after its trigger so it sees the bitmap including that event; any new
  // trigger mid-scan simply reloads the pointer and starts over.
  always_comb begin
    state_next = state;
    note_next  = out_note;
    gate_next  = out_gate;
    ptr_load   = 1'b0;
    ptr_step   = 1'b0;
    if (all_off) begin
      state_next = IDLE;
      gate_next  = 1'b0;
    end else if (direct_sel) begin
      state_next = IDLE;
      note_next  = note;
      gate_next  = 1'b1;
    end else if (scan_req) begin
      state_next = SCAN;
      ptr_load   = 1'b1;
    end else if (state == SCAN) begin
      if (keys[ptr]) begin
        state_next = IDLE;
        note_next  = ptr;
        gate_next  = 1'b1;
      end else if (at_terminal) begin
        state_next = IDLE;
        gate_next  = 1'b0;
      end else begin
        ptr_step = 1'b1;
      end
    end
  end

  // Registered state and outputs. The retrigger is derived from the same
  // next values that load out_note/out_gate, so it lands on the update edge;
  // a rescan that reselects the sounding note leaves it quiet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keys       <= '0;
      state      <= IDLE;
      mode_q     <= MODE_HIGH;
      out_note   <= '0;
      out_gate   <= 1'b0;
      out_retrig <= 1'b0;
    end else begin
      keys       <= keys_next;
      state      <= state_next;
      mode_q     <= mode;
      out_note   <= note_next;
      out_gate   <= gate_next;
      out_retrig <= gate_next
                 && (!out_gate || (RETRIG_LEGATO && (note_next != out_note)));
    end
  end

  assign busy = (state == SCAN);

endmodule
